// File: rtl/vector_mem_pkg.sv
// Shared types and default geometry for the MEM-stage vector memory sequencer.
package vector_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int VEC_W_DEF  = 192;
  localparam int BEAT_W_DEF = 32;
  localparam int ADDR_W_DEF = 32;

  function automatic int calc_cnt_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  localparam int BEATS      = VEC_W_DEF / BEAT_W_DEF;
  localparam int BEAT_BYTES = BEAT_W_DEF / 8;
  localparam int CNT_W      = calc_cnt_w(BEATS);

endpackage

// File: rtl/vector_mem_sequencer.sv
// Splits scalar/vector MEM-stage accesses into BEAT_W-wide memory beats,
// assembles load data and stalls the pipeline until the access completes.
module vector_mem_sequencer
  import vector_mem_pkg::*;
#(
  parameter int VEC_W  = VEC_W_DEF,
  parameter int BEAT_W = BEAT_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic              req_vec,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [VEC_W-1:0]  req_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BEAT_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [BEAT_W-1:0] mem_rdata,
  output logic              stall,
  output logic              done,
  output logic [VEC_W-1:0]  rdata
);

  localparam int L_BEATS      = VEC_W / BEAT_W;
  localparam int L_BEAT_BYTES = BEAT_W / 8;
  localparam int L_CNT_W      = calc_cnt_w(L_BEATS);

  if ((VEC_W % BEAT_W) != 0) begin : g_bad_geometry
    $error("vector_mem_sequencer: VEC_W must be a multiple of BEAT_W");
  end

  state_t              r_state;
  logic [L_CNT_W-1:0]  r_beat;
  logic                r_we;
  logic                r_vec;
  logic [ADDR_W-1:0]   r_addr;
  logic [VEC_W-1:0]    r_wsh;
  logic [VEC_W-1:0]    r_rdata;
  logic                r_mem_req;
  logic                r_done;
  logic                w_last;
  logic                w_accept;

  assign w_last   = r_vec ? (r_beat == L_CNT_W'(L_BEATS - 1)) : 1'b1;
  assign w_accept = r_mem_req & mem_ready;

  // Store data is shifted down one beat per accepted beat so the port always reads the low slice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_beat    <= '0;
      r_we      <= 1'b0;
      r_vec     <= 1'b0;
      r_addr    <= '0;
      r_wsh     <= '0;
      r_rdata   <= '0;
      r_mem_req <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_state   <= ACCESS;
            r_we      <= req_we;
            r_vec     <= req_vec;
            r_addr    <= req_addr;
            r_wsh     <= req_wdata;
            r_beat    <= '0;
            r_rdata   <= '0;
            r_mem_req <= 1'b1;
          end
        end
        ACCESS: begin
          if (w_accept) begin
            if (!r_we) begin
              r_rdata[int'(r_beat)*BEAT_W +: BEAT_W] <= mem_rdata;
            end
            if (w_last) begin
              r_state   <= DONE;
              r_mem_req <= 1'b0;
              r_done    <= 1'b1;
            end else begin
              r_beat <= r_beat + L_CNT_W'(1);
              r_addr <= r_addr + ADDR_W'(L_BEAT_BYTES);
              r_wsh  <= r_wsh >> BEAT_W;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state   <= IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_req & r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_mem_req ? r_wsh[BEAT_W-1:0] : '0;
  assign stall     = ((r_state == IDLE) & req_valid) | (r_state == ACCESS);
  assign done      = r_done;
  assign rdata     = r_rdata;

endmodule
